// File: rtl/rv_branch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv_branch_pkg
// Description : Shared encodings for the branch resolve unit.
//               Includes the branch opcode, the RV32I branch funct3 codes,
//               the BHT 2-bit counter states and the counter update rule.
// Revision    : 1.0 - initial release
// ============================================================================
package rv_branch_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    BEQ  = 3'd0,
    BNE  = 3'd1,
    BLT  = 3'd4,
    BGE  = 3'd5,
    BLTU = 3'd6,
    BGEU = 3'd7
  } br_funct3_e;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_state_e;

  // Saturating 2-bit counter step: toward ST on taken, toward SNT otherwise.
  function automatic bht_state_e bht_next(input bht_state_e state, input logic taken);
    bht_state_e nxt;
    case (state)
      SNT:     nxt = taken ? WNT : SNT;
      WNT:     nxt = taken ? WT  : SNT;
      WT:      nxt = taken ? ST  : WNT;
      ST:      nxt = taken ? ST  : WT;
      default: nxt = WNT;
    endcase
    return nxt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/branch_resolve_unit_bht.sv
`default_nettype none
// ============================================================================
// Module      : bht_table
// Description : Branch history table of 2-bit saturating counters.
//               It has one combinational read port and one synchronous
//               read-modify-write update port. Reset puts every entry in WNT.
// Revision    : 1.0 - initial release
// ============================================================================
module bht_table
  import rv_branch_pkg::*;
#(
  parameter int BHT_ENTRIES = 64,
  parameter int IDX_W       = $clog2(BHT_ENTRIES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_idx,
  output bht_state_e       rd_state,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  bht_state_e r_tbl [BHT_ENTRIES];

  // Read returns the stored value, so a same-cycle update is not yet visible.
  assign rd_state = r_tbl[rd_idx];

  // Reset all counters to weakly-not-taken; otherwise step the addressed one.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        r_tbl[i] <= WNT;
      end
    end else if (wr_en) begin
      r_tbl[wr_idx] <= bht_next(r_tbl[wr_idx], wr_taken);
    end
  end

endmodule
`default_nettype wire

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_unit
// Description : Resolves RV32I conditional branches and computes the
//               next-instruction address. Results are registered with one
//               cycle of latency. The unit updates the BHT and keeps
//               saturating branch and mispredict counters.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve_unit
  import rv_branch_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [XLEN-1:0]  lk_pc,
  output logic             lk_taken,
  input  logic             in_valid,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic [12:0]      imm,
  input  logic [XLEN-1:0]  in1,
  input  logic [XLEN-1:0]  in2,
  input  logic [XLEN-1:0]  pc,
  input  logic             pred_taken,
  output logic             out_valid,
  output logic [XLEN-1:0]  iaddr,
  output logic             taken,
  output logic             mispredict,
  input  logic             clear_stats,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mp_count
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic            w_is_branch;
  logic            w_taken;
  logic            w_mispredict;
  logic            w_update;
  logic [XLEN-1:0] w_imm_sext;
  logic [XLEN-1:0] w_iaddr;
  bht_state_e      w_lk_state;

  logic [XLEN-1:0]  r_iaddr;
  logic             r_valid;
  logic             r_taken;
  logic             r_mispredict;
  logic [CNT_W-1:0] r_br_cnt;
  logic [CNT_W-1:0] r_mp_cnt;

  // Address bits outside the BHT index and the immediate LSB are unused.
  logic w_unused_bits;
  assign w_unused_bits = ^{lk_pc[XLEN-1:IDX_W+2], lk_pc[1:0],
                           pc[XLEN-1:IDX_W+2], pc[1:0], imm[0]};

  // Branch recognition: funct3 codes 2 and 3 are not branches.
  assign w_is_branch = (opcode == OP_BRANCH) && (funct3 != 3'd2) && (funct3 != 3'd3);

  // Evaluate the branch condition; illegal encodings never count as taken.
  always_comb begin
    w_taken = 1'b0;
    if (w_is_branch) begin
      case (funct3)
        BEQ:     w_taken = (in1 == in2);
        BNE:     w_taken = (in1 != in2);
        BLT:     w_taken = ($signed(in1) <  $signed(in2));
        BGE:     w_taken = ($signed(in1) >= $signed(in2));
        BLTU:    w_taken = (in1 <  in2);
        BGEU:    w_taken = (in1 >= in2);
        default: w_taken = 1'b0;
      endcase
    end
  end

  assign w_imm_sext   = {{(XLEN-13){imm[12]}}, imm[12:1], 1'b0};
  assign w_iaddr      = w_taken ? (pc + w_imm_sext) : (pc + XLEN'(4));
  assign w_mispredict = w_is_branch && (w_taken != pred_taken);
  assign w_update     = in_valid && w_is_branch;

  bht_table #(
    .BHT_ENTRIES (BHT_ENTRIES),
    .IDX_W       (IDX_W)
  ) u_bht (
    .clk      (clk),
    .reset    (reset),
    .rd_idx   (lk_pc[IDX_W+1:2]),
    .rd_state (w_lk_state),
    .wr_en    (w_update),
    .wr_idx   (pc[IDX_W+1:2]),
    .wr_taken (w_taken)
  );

  assign lk_taken = w_lk_state[1];

  // Result register: valid pulses for one cycle, data holds when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid      <= 1'b0;
      r_iaddr      <= '0;
      r_taken      <= 1'b0;
      r_mispredict <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_iaddr      <= w_iaddr;
        r_taken      <= w_taken;
        r_mispredict <= w_mispredict;
      end
    end
  end

  // Saturating performance counters; clear_stats beats a same-cycle increment.
  always_ff @(posedge clk) begin
    if (reset || clear_stats) begin
      r_br_cnt <= '0;
      r_mp_cnt <= '0;
    end else if (w_update) begin
      if (!(&r_br_cnt)) begin
        r_br_cnt <= r_br_cnt + CNT_W'(1);
      end
      if (w_mispredict && !(&r_mp_cnt)) begin
        r_mp_cnt <= r_mp_cnt + CNT_W'(1);
      end
    end
  end

  assign out_valid  = r_valid;
  assign iaddr      = r_iaddr;
  assign taken      = r_taken;
  assign mispredict = r_mispredict;
  assign br_count   = r_br_cnt;
  assign mp_count   = r_mp_cnt;

endmodule
`default_nettype wire
